// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: fetch/decode/execute/mem sequencer (PC redirect, flush, bubbles, halt drain); PIPE_PERF_CNT_EN adds perf counters
module pipeline_ctrl #(
  parameter int ADDR_W       = 8,
  parameter int STALL_CYCLES = 1,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              dec_load_use,
  input  logic              dec_jump,
  input  logic [ADDR_W-1:0] dec_jump_tgt,
  input  logic              dec_halt,
  input  logic              exe_br_taken,
  input  logic [ADDR_W-1:0] exe_br_tgt,
  output logic              pc_en,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_next,
  output logic              if_flush,
  output logic              id_bubble,
  output logic              busy,
  output logic              halted
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  perf_cycles,
  output logic [CNT_W-1:0]  perf_stalls,
  output logic [CNT_W-1:0]  perf_flushes
`endif
);
  localparam int SW = STALL_CYCLES > 1 ? $clog2(STALL_CYCLES) : 1;
  localparam int DW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE, RUN, STALL, FLUSH, DRAIN, HALTED} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] stall_q, stall_d;
  logic [DW-1:0] drain_q, drain_d;
  // state and hazard counters; async active-low reset drops any pending redirect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      stall_q <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      drain_q <= drain_d;
    end
  end
  // next state and zero-latency pipeline control from state plus this cycle's events
  always_comb begin
    state_d   = state_q;
    stall_d   = stall_q;
    drain_d   = drain_q;
    pc_en     = 1'b0;
    pc_load   = 1'b0;
    pc_next   = '0;
    if_flush  = 1'b0;
    id_bubble = 1'b0;
    halted    = 1'b0;
    case (state_q)
      IDLE, HALTED: begin
        halted = state_q == HALTED;
        if (start && rst) begin
          pc_load  = 1'b1;
          if_flush = 1'b1;
          state_d  = FLUSH;
        end
      end
      RUN: begin
        pc_en = 1'b1;
        if (exe_br_taken) begin
          pc_load   = 1'b1;
          pc_next   = exe_br_tgt;
          if_flush  = 1'b1;
          id_bubble = 1'b1;
          state_d   = FLUSH;
        end else if (dec_jump) begin
          pc_load  = 1'b1;
          pc_next  = dec_jump_tgt;
          if_flush = 1'b1;
          state_d  = FLUSH;
        end else if (dec_halt) begin
          pc_en    = 1'b0;
          if_flush = 1'b1;
          drain_d  = DW'(DRAIN_CYCLES - 1);
          state_d  = DRAIN;
        end else if (dec_load_use) begin
          pc_en     = 1'b0;
          id_bubble = 1'b1;
          stall_d   = SW'(STALL_CYCLES - 1);
          state_d   = STALL;
        end
      end
      STALL: begin
        id_bubble = 1'b1;
        if (exe_br_taken) begin
          pc_load  = 1'b1;
          pc_next  = exe_br_tgt;
          if_flush = 1'b1;
          state_d  = FLUSH;
        end else begin
          state_d = stall_q == '0 ? RUN : STALL;
          stall_d = stall_q == '0 ? stall_q : stall_q - SW'(1);
        end
      end
      FLUSH: begin
        pc_en    = 1'b1;
        if_flush = 1'b1;
        state_d  = RUN;
      end
      DRAIN: begin
        if_flush  = 1'b1;
        id_bubble = 1'b1;
        state_d   = drain_q == '0 ? HALTED : DRAIN;
        drain_d   = drain_q == '0 ? drain_q : drain_q - DW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  assign busy = state_q inside {RUN, STALL, FLUSH, DRAIN};
`ifdef PIPE_PERF_CNT_EN
  logic perf_clr, stall_evt;
  assign perf_clr  = (state_q == IDLE || state_q == HALTED) && start;
  assign stall_evt = state_q == STALL || (state_q == RUN && state_d == STALL);
  // saturating perf counters; a start clears them, taking precedence over its own redirect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cycles  <= '0;
      perf_stalls  <= '0;
      perf_flushes <= '0;
    end else if (perf_clr) begin
      perf_cycles  <= '0;
      perf_stalls  <= '0;
      perf_flushes <= '0;
    end else begin
      perf_cycles  <= busy && ~&perf_cycles ? perf_cycles + 1'b1 : perf_cycles;
      perf_stalls  <= stall_evt && ~&perf_stalls ? perf_stalls + 1'b1 : perf_stalls;
      perf_flushes <= pc_load && ~&perf_flushes ? perf_flushes + 1'b1 : perf_flushes;
    end
  end
`endif
endmodule
